// File: rtl/entry_timeout_timer.sv
// Seconds-resolution inactivity timer for the passcode-entry FSM.
// Optional near-expiry warning enabled by defining ENTRY_TIMER_WARN_EN.
module entry_timeout_timer #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TIMEOUT_S = 20,
    parameter int SEC_W     = 5,
    parameter int WARN_S    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             restart,
    output logic [SEC_W-1:0] seconds,
    output logic             tick,
    output logic             timeout,
    output logic             timeout_pulse,
    output logic             warn
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_TC    = PRE_W'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0] SEC_LIMIT = SEC_W'(TIMEOUT_S);
    localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(TIMEOUT_S - 1);

    logic [PRE_W-1:0] pre;
    logic             pre_wrap;
    logic             clear;
    logic [SEC_W-1:0] seconds_nxt;

    assign pre_wrap    = (pre == PRE_TC);
    assign clear       = restart || !run;
    assign seconds_nxt = pre_wrap ? seconds + SEC_W'(1) : seconds;

    // Once timeout is set the counter freezes until cleared, so seconds never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre           <= '0;
            seconds       <= '0;
            tick          <= 1'b0;
            timeout       <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            tick          <= 1'b0;
            timeout_pulse <= 1'b0;
            if (clear) begin
                pre     <= '0;
                seconds <= '0;
                timeout <= 1'b0;
            end else if (!timeout) begin
                if (pre_wrap) begin
                    pre     <= '0;
                    seconds <= seconds_nxt;
                    tick    <= 1'b1;
                    if (seconds == SEC_LAST) begin
                        timeout       <= 1'b1;
                        timeout_pulse <= 1'b1;
                    end
                end else begin
                    pre <= pre + PRE_W'(1);
                end
            end
        end
    end

`ifdef ENTRY_TIMER_WARN_EN
    localparam logic [SEC_W-1:0] WARN_TH = SEC_W'(TIMEOUT_S - WARN_S);

    // Evaluated on the upcoming seconds value so warn lines up with seconds.
    always_ff @(posedge clk) begin
        if (rst || clear || timeout) begin
            warn <= 1'b0;
        end else begin
            warn <= (seconds_nxt >= WARN_TH) && (seconds_nxt != SEC_LIMIT);
        end
    end
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_entry_timeout_timer.sv
// Self-checking bench for entry_timeout_timer: vector table, corner sequences,
// and randomized run/restart/rst traffic against an elapsed-cycle model.
module tb_entry_timeout_timer;

    localparam int CLK_HZ    = 4;
    localparam int TIMEOUT_S = 3;
    localparam int SEC_W     = 2;
    localparam int WARN_S    = 1;
    localparam int LIMIT     = TIMEOUT_S * CLK_HZ;
`ifdef ENTRY_TIMER_WARN_EN
    localparam bit WARN_ON = 1'b1;
`else
    localparam bit WARN_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             run = 1'b0;
    logic             restart = 1'b0;
    logic [SEC_W-1:0] seconds;
    logic             tick, timeout, timeout_pulse, warn;

    int total = 0;
    int bad   = 0;

    // Reference model: cycles counted since the last clear, capped at expiry.
    int elapsed = 0;
    bit counted = 0;
    int m_seconds, m_tick, m_timeout, m_pulse, m_warn;

    typedef struct {
        bit rst, run, restart;
        int seconds, tick, timeout, pulse, warn;
    } vec_t;
    vec_t vecs[$];

    entry_timeout_timer #(
        .CLK_HZ(CLK_HZ), .TIMEOUT_S(TIMEOUT_S), .SEC_W(SEC_W), .WARN_S(WARN_S)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .restart(restart),
        .seconds(seconds), .tick(tick), .timeout(timeout),
        .timeout_pulse(timeout_pulse), .warn(warn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit rn, input bit rs);
        int prev;
        prev = elapsed;
        counted = 0;
        if (r || rs || !rn) elapsed = 0;
        else if (elapsed < LIMIT) begin
            elapsed = elapsed + 1;
            counted = 1;
        end
        m_seconds = elapsed / CLK_HZ;
        m_timeout = (elapsed == LIMIT);
        m_tick    = counted && (elapsed % CLK_HZ == 0);
        m_pulse   = counted && (elapsed == LIMIT) && (prev != LIMIT);
        m_warn    = WARN_ON && counted && (m_seconds >= TIMEOUT_S - WARN_S) && !m_timeout;
    endtask

    task automatic cycle(input bit r, input bit rn, input bit rs);
        rst = r; run = rn; restart = rs;
        @(posedge clk);
        model_step(r, rn, rs);
        #1;
        chk("model_seconds", int'(seconds), m_seconds);
        chk("model_tick", int'(tick), m_tick);
        chk("model_timeout", int'(timeout), m_timeout);
        chk("model_pulse", int'(timeout_pulse), m_pulse);
        chk("model_warn", int'(warn), m_warn);
    endtask

    initial begin
        vec_t v;
        // Reset for two cycles, restart pulse, then sixteen run cycles.
        for (int i = 0; i < 2; i++) begin
            v = '{rst:1, run:1, restart:0, seconds:0, tick:0, timeout:0, pulse:0, warn:0};
            vecs.push_back(v);
        end
        v = '{rst:0, run:1, restart:1, seconds:0, tick:0, timeout:0, pulse:0, warn:0};
        vecs.push_back(v);
        for (int k = 1; k <= 16; k++) begin
            v.rst = 0; v.run = 1; v.restart = 0;
            v.seconds = (k >= 12) ? 3 : k / 4;
            v.tick    = (k % 4 == 0) && (k <= 12);
            v.timeout = (k >= 12);
            v.pulse   = (k == 12);
            v.warn    = WARN_ON && (k >= 8) && (k < 12);
            vecs.push_back(v);
        end

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].run, vecs[i].restart);
            chk("vec_seconds", int'(seconds), vecs[i].seconds);
            chk("vec_tick", int'(tick), vecs[i].tick);
            chk("vec_timeout", int'(timeout), vecs[i].timeout);
            chk("vec_pulse", int'(timeout_pulse), vecs[i].pulse);
            chk("vec_warn", int'(warn), vecs[i].warn);
        end

        // Restart mid-count at seconds=1, pre=2.
        cycle(0, 1, 1);
        for (int k = 0; k < 6; k++) cycle(0, 1, 0);
        chk("s3_pre_restart_seconds", int'(seconds), 1);
        cycle(0, 1, 1);
        chk("s3_after_restart_seconds", int'(seconds), 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0);
        chk("s3_still_zero", int'(seconds), 0);
        cycle(0, 1, 0);
        chk("s3_first_second", int'(seconds), 1);
        chk("s3_first_tick", int'(tick), 1);

        // run dropped at seconds=2, pre=2 clears rather than holds.
        cycle(0, 1, 1);
        for (int k = 0; k < 10; k++) cycle(0, 1, 0);
        chk("s4_before_drop", int'(seconds), 2);
        cycle(0, 0, 0);
        chk("s4_cleared", int'(seconds), 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0);
        chk("s4_no_early_tick", int'(tick), 0);
        cycle(0, 1, 0);
        chk("s4_tick_after_4", int'(tick), 1);
        chk("s4_seconds_after_4", int'(seconds), 1);

        // Restart on the terminal-count cycle suppresses the tick.
        cycle(0, 1, 1);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0);
        cycle(0, 1, 1);
        chk("s5_no_tick", int'(tick), 0);
        chk("s5_seconds", int'(seconds), 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0);
        chk("s5_pre_cleared", int'(tick), 0);
        cycle(0, 1, 0);
        chk("s5_tick_after_4", int'(tick), 1);

        // Randomized traffic, biased toward long runs so expiry is reached often.
        for (int n = 0; n < 4000; n++) begin
            bit r, rn, rs;
            r  = ($urandom_range(0, 199) == 0);
            rn = ($urandom_range(0, 39) != 0);
            rs = ($urandom_range(0, 49) == 0);
            cycle(r, rn, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
